multi_cycle_ctrl: RTL

//   Moore FSM that sequences the multi-cycle MIPS datapath. It decodes the

---
 rtl/multi_cycle_ctrl_if.sv | 23 ++
 rtl/multi_cycle_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS sequencer and its datapath.
// master = sequencer, slave = datapath.
interface multi_cycle_ctrl_if;
  logic        mio_ready;
  logic [31:0] inst;
  logic        overflow;
  logic [15:0] ctrl_signals;
  logic [3:0]  ALU_operation;
  logic        Beq;
  logic        Sign;
  logic [3:0]  state;
  logic        illegal;

  modport master (
    input  mio_ready, inst, overflow,
    output ctrl_signals, ALU_operation, Beq, Sign, state, illegal
  );

  modport slave (
    output mio_ready, inst, overflow,
    input  ctrl_signals, ALU_operation, Beq, Sign, state, illegal
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Moore sequencer for the multi-cycle MIPS datapath: decodes IR per state and
// drives datapath controls; memory states stall on mio_ready.
module multi_cycle_ctrl #(
  parameter logic [3:0] ALU_AND = 4'b0000,
  parameter logic [3:0] ALU_OR  = 4'b0001,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110,
  parameter logic [3:0] ALU_SLT = 4'b0111,
  parameter logic [3:0] ALU_NOR = 4'b1100,
  parameter logic [3:0] ALU_XOR = 4'b1101,
  parameter logic [3:0] ALU_SLL = 4'b0011,
  parameter logic [3:0] ALU_SRL = 4'b0101
) (
  input  logic                clk,
  input  logic                reset,
  multi_cycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_MADDR = 4'd2, S_MRD = 4'd3, S_LWB = 4'd4,
    S_MWR = 4'd5, S_REXE = 4'd6, S_RWB = 4'd7, S_BR = 4'd8, S_IEXE = 4'd9,
    S_IWB = 4'd10, S_LUI = 4'd11, S_JMP = 4'd12, S_JAL = 4'd13, S_JR = 4'd14,
    S_BAD = 4'd15
  } state_e;

  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011,
                         OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
                         OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101,
                         OP_XORI = 6'b001110, OP_LUI  = 6'b001111, OP_LW   = 6'b100011,
                         OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR = 6'b001000, FN_ADD = 6'b100000, FN_SUB = 6'b100010;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   ovf_q, ovf_d;

  logic [5:0] op, funct;
  assign op    = bus.inst[31:26];
  assign funct = bus.inst[5:0];

  logic [3:0] r_alu, i_alu;
  logic       r_known, i_sign;

  always_comb begin
    r_known = 1'b1;
    r_alu   = ALU_ADD;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100110: r_alu = ALU_XOR;
      6'b100111: r_alu = ALU_NOR;
      6'b101010: r_alu = ALU_SLT;
      6'b000000: r_alu = ALU_SLL;
      6'b000010: r_alu = ALU_SRL;
      default:   r_known = 1'b0;
    endcase
  end

  // Logical immediates are zero-extended; IR is stable through IWB so this
  // decode also serves the writeback state.
  always_comb begin
    i_alu  = ALU_ADD;
    i_sign = 1'b1;
    case (op)
      OP_SLTI: i_alu = ALU_SLT;
      OP_ANDI: begin i_alu = ALU_AND; i_sign = 1'b0; end
      OP_ORI:  begin i_alu = ALU_OR;  i_sign = 1'b0; end
      OP_XORI: begin i_alu = ALU_XOR; i_sign = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    ovf_d     = ovf_q;
    case (state_q)
      S_IF:    if (bus.mio_ready) state_d = S_ID;
      S_ID: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MADDR;
          OP_R: begin
            if (funct == FN_JR) state_d = S_JR;
            else if (r_known)   state_d = S_REXE;
            else begin
              state_d   = S_IF;
              illegal_d = 1'b1;
            end
          end
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_IEXE;
          OP_LUI:  state_d = S_LUI;
          OP_J:    state_d = S_JMP;
          OP_JAL:  state_d = S_JAL;
          default: begin
            state_d   = S_IF;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MADDR: state_d = (op == OP_SW) ? S_MWR : S_MRD;
      S_MRD:   if (bus.mio_ready) state_d = S_LWB;
      S_MWR:   if (bus.mio_ready) state_d = S_IF;
      S_REXE: begin
        ovf_d   = (funct == FN_ADD || funct == FN_SUB) ? bus.overflow : 1'b0;
        state_d = S_RWB;
      end
      S_IEXE: begin
        ovf_d   = (op == OP_ADDI) ? bus.overflow : 1'b0;
        state_d = S_IWB;
      end
      S_JR:    if (bus.mio_ready) state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  ctrl_t      ctrl;
  logic [3:0] alu_op;
  logic       beq, sign;

  always_comb begin
    ctrl   = '0;
    alu_op = ALU_ADD;
    beq    = 1'b0;
    sign   = 1'b1;
    case (state_q)
      S_ID: ctrl.alu_src_b = 2'b11;
      S_MADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MRD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_LWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 2'b01;
      end
      S_MWR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_REXE: begin
        ctrl.alu_src_a = 1'b1;
        alu_op         = r_alu;
      end
      S_RWB: begin
        ctrl.reg_dst   = 2'b01;
        ctrl.reg_write = ~ovf_q;
      end
      S_BR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        alu_op             = ALU_SUB;
        beq                = (op == OP_BEQ);
      end
      S_IEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        alu_op         = i_alu;
        sign           = i_sign;
      end
      S_IWB: begin
        ctrl.reg_write = ~ovf_q;
        alu_op         = i_alu;
        sign           = i_sign;
      end
      S_LUI: begin
        ctrl.mem_to_reg = 2'b10;
        ctrl.reg_write  = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      // PC already holds PC+4 here, so the link value comes straight from PC.
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = 2'b10;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 2'b10;
        ctrl.mem_to_reg = 2'b11;
      end
      S_JR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.pc_write  = bus.mio_ready;
        alu_op         = ALU_OR;
      end
      default: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.pc_write  = bus.mio_ready;
      end
    endcase
  end

  assign bus.ctrl_signals  = ctrl;
  assign bus.ALU_operation = alu_op;
  assign bus.Beq           = beq;
  assign bus.Sign          = sign;
  assign bus.state         = state_q;
  assign bus.illegal       = illegal_q;

endmodule
